bank_reg_sb: RTL

Parametrised successor to the processor register bank: a 2-read / 2-write register file with a per-register pending-load scoreboard. It sits in the decode/writeback stage of the ARMv4 core. Reads of the PC index return the externally supplied PC+8 value. The scoreboard lets decode stall on operands whose load has not returned yet.

---
 rtl/bank_reg_sb.sv | 130 +++++++++++++
 1 files changed

// File: rtl/bank_reg_sb.sv
// bank_reg_sb: 2-read / 2-write register file with a per-register pending-load scoreboard.
// Latency: reads are combinational; writes and busy updates appear the cycle after the writing edge.
// Backpressure: none. Decode stalls on busy1/busy2; the bank itself always accepts writes and marks.
//
// Build option: BANKREG_BYPASS_EN forwards same-cycle write data and load-return busy clears
// straight to the read ports. Without it, reads show registered state only.
//
// Ports:
//   CLK, rst             clock; asynchronous active-high reset
//   A1/RD1/busy1         read port 1: address, data, scoreboard bit
//   A2/RD2/busy2         read port 2: address, data, scoreboard bit
//   PCplus               PC+8, returned for reads of PC_IDX
//   WE3/A3/WD3           ALU write port
//   WEL/AL/WDL           load-return write port; also clears busy[AL]
//   mark/mark_a          load issued: sets busy[mark_a]
//   busy_any             OR of all registered busy bits
//   conflict             one-cycle pulse: both write ports hit the same non-PC address last edge
module bank_reg_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int PC_IDX = 15
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic [ADDR_W-1:0] A1,
   input  logic [ADDR_W-1:0] A2,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   output logic              busy1,
   output logic              busy2,
   input  logic [DATA_W-1:0] PCplus,
   input  logic              WE3,
   input  logic [ADDR_W-1:0] A3,
   input  logic [DATA_W-1:0] WD3,
   input  logic              WEL,
   input  logic [ADDR_W-1:0] AL,
   input  logic [DATA_W-1:0] WDL,
   input  logic              mark,
   input  logic [ADDR_W-1:0] mark_a,
   output logic              busy_any,
   output logic              conflict
);

   localparam int              NREG = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

   // The PC_IDX slot exists in the array only to keep indexing simple; it is never
   // written after reset and never read out (reads of PC_IDX return PCplus).
   logic [DATA_W-1:0] regs [NREG];
   logic [NREG-1:0]   busy;
   logic [NREG-1:0]   busy_nxt;

   logic ld_wr;
   logic alu_hit;
   logic alu_wr;

   assign ld_wr   = WEL && (AL != PC_A);
   assign alu_hit = WE3 && (A3 != PC_A);
   // Load return wins a same-address collision; the ALU data is dropped.
   assign alu_wr  = alu_hit && !(ld_wr && (AL == A3));

   // Clear first, then set, so a same-cycle mark on the returning address keeps the bit high.
   always_comb begin
      busy_nxt = busy;
      if (ld_wr)
         busy_nxt[AL] = 1'b0;
      if (mark && (mark_a != PC_A))
         busy_nxt[mark_a] = 1'b1;
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
         busy     <= '0;
         conflict <= 1'b0;
      end else begin
         if (alu_wr)
            regs[A3] <= WD3;
         if (ld_wr)
            regs[AL] <= WDL;
         busy     <= busy_nxt;
         conflict <= alu_hit && ld_wr && (A3 == AL);
      end
   end

   assign busy_any = |busy;

   // Read port 1
   always_comb begin
      RD1   = regs[A1];
      busy1 = busy[A1];
      if (A1 == PC_A) begin
         RD1   = PCplus;
         busy1 = 1'b0;
      end
`ifdef BANKREG_BYPASS_EN
      // Forwarding is suppressed while reset holds the bank, since those writes never land.
      else if (!rst) begin
         if (ld_wr && (AL == A1))
            RD1 = WDL;
         else if (alu_hit && (A3 == A1))
            RD1 = WD3;
         if (ld_wr && (AL == A1) && !(mark && (mark_a == A1)))
            busy1 = 1'b0;
      end
`endif
   end

   // Read port 2
   always_comb begin
      RD2   = regs[A2];
      busy2 = busy[A2];
      if (A2 == PC_A) begin
         RD2   = PCplus;
         busy2 = 1'b0;
      end
`ifdef BANKREG_BYPASS_EN
      else if (!rst) begin
         if (ld_wr && (AL == A2))
            RD2 = WDL;
         else if (alu_hit && (A3 == A2))
            RD2 = WD3;
         if (ld_wr && (AL == A2) && !(mark && (mark_a == A2)))
            busy2 = 1'b0;
      end
`endif
   end

endmodule
